// File: rtl/mouse_cmd_sequencer.sv
// PS/2 mouse command sequencer: plays a fixed configuration script to the
// mouse (sample rate 200/100/80, read ID, enable streaming), retrying each
// byte on NAK, bad reply or timeout, and arbitrating single host commands
// in between scripts.
module mouse_cmd_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
  parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_host_req,
  input  logic [7:0] i_host_byte,
  output logic       o_host_gnt,
  output logic       o_host_done,
  output logic       o_host_ok,
  output logic       o_send_byte,
  output logic [7:0] o_byte_to_send,
  input  logic       i_byte_sent,
  output logic       o_read_enable,
  input  logic [7:0] i_byte_read,
  input  logic [1:0] i_byte_error_code,
  input  logic       i_byte_ready,
  output logic [7:0] o_mouse_id,
  output logic       o_stream_ready,
  output logic       o_busy,
  output logic       o_error
);

  localparam logic [7:0] ACK_BYTE = 8'hFA;
  localparam logic [7:0] GET_ID   = 8'hF2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_ACK,
    S_WAIT_ID,
    S_NEXT,
    S_STREAM,
    S_FAULT
  } state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_ptr, w_ptr_next;
  logic [1:0]  r_retry, w_retry_next;
  logic [23:0] r_cnt, w_cnt_next;
  logic [7:0]  r_byte, w_byte_next;
  logic [7:0]  r_mouse_id, w_mouse_id_next;
  logic        r_stream_ready, w_stream_ready_next;
  logic        r_error, w_error_next;
  logic        r_host_mode, w_host_mode_next;
  logic        r_rest_stream, w_rest_stream_next;
  logic        r_host_done, w_host_done_next;
  logic        r_host_ok, w_host_ok_next;

  logic [7:0]  w_rom_byte;
  logic        w_timeout;
  logic        w_fail;
  state_t      w_rest_state;

  // Configuration script ROM: set rate 200, set rate 100, set rate 80, get ID, enable.
  always_comb begin
    w_rom_byte = 8'hF3;
    case (r_ptr)
      3'd0: w_rom_byte = 8'hF3;
      3'd1: w_rom_byte = 8'hC8;
      3'd2: w_rom_byte = 8'hF3;
      3'd3: w_rom_byte = 8'h64;
      3'd4: w_rom_byte = 8'hF3;
      3'd5: w_rom_byte = 8'h50;
      3'd6: w_rom_byte = 8'hF2;
      3'd7: w_rom_byte = 8'hF4;
      default: w_rom_byte = 8'hF3;
    endcase
  end

  assign w_timeout    = (r_cnt == (TIMEOUT_CYCLES - 24'd1));
  assign w_rest_state = r_rest_stream ? S_STREAM : S_IDLE;

  // Next-state logic; any failure detected in a wait state is resolved after the case.
  always_comb begin
    w_state_next        = r_state;
    w_ptr_next          = r_ptr;
    w_retry_next        = r_retry;
    w_cnt_next          = r_cnt;
    w_byte_next         = r_byte;
    w_mouse_id_next     = r_mouse_id;
    w_stream_ready_next = r_stream_ready;
    w_error_next        = r_error;
    w_host_mode_next    = r_host_mode;
    w_rest_stream_next  = r_rest_stream;
    w_host_done_next    = 1'b0;
    w_host_ok_next      = 1'b0;
    w_fail              = 1'b0;

    case (r_state)
      S_IDLE, S_STREAM, S_FAULT: begin
        if (i_start) begin
          // Script start has priority over a simultaneous host request.
          w_state_next        = S_LOAD;
          w_ptr_next          = 3'd0;
          w_retry_next        = 2'd0;
          w_stream_ready_next = 1'b0;
          w_error_next        = 1'b0;
          w_host_mode_next    = 1'b0;
        end else if (i_host_req && (r_state != S_FAULT)) begin
          w_state_next       = S_LOAD;
          w_retry_next       = 2'd0;
          w_host_mode_next   = 1'b1;
          w_rest_stream_next = (r_state == S_STREAM);
        end
      end

      S_LOAD: begin
        w_byte_next  = r_host_mode ? i_host_byte : w_rom_byte;
        w_state_next = S_SEND;
      end

      S_SEND: begin
        w_state_next = S_WAIT_SENT;
        w_cnt_next   = 24'd0;
      end

      S_WAIT_SENT: begin
        if (i_byte_sent) begin
          w_state_next = S_WAIT_ACK;
          w_cnt_next   = 24'd0;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end

      S_WAIT_ACK: begin
        if (i_byte_ready) begin
          if ((i_byte_error_code == 2'b00) && (i_byte_read == ACK_BYTE)) begin
            if (!r_host_mode && (r_byte == GET_ID)) begin
              w_state_next = S_WAIT_ID;
              w_cnt_next   = 24'd0;
            end else begin
              w_state_next = S_NEXT;
            end
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end

      S_WAIT_ID: begin
        if (i_byte_ready && (i_byte_error_code == 2'b00)) begin
          w_mouse_id_next = i_byte_read;
          w_state_next    = S_NEXT;
        end else if (i_byte_ready || w_timeout) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end

      S_NEXT: begin
        if (r_host_mode) begin
          w_host_done_next = 1'b1;
          w_host_ok_next   = 1'b1;
          w_state_next     = w_rest_state;
        end else begin
          w_retry_next = 2'd0;
          if (r_ptr == 3'd7) begin
            w_state_next        = S_STREAM;
            w_stream_ready_next = 1'b1;
          end else begin
            w_ptr_next   = r_ptr + 3'd1;
            w_state_next = S_LOAD;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // A failed attempt resends the same byte until the retry budget is spent.
    if (w_fail) begin
      if (r_retry < MAX_RETRY) begin
        w_retry_next = r_retry + 2'd1;
        w_state_next = S_SEND;
      end else if (r_host_mode) begin
        w_host_done_next = 1'b1;
        w_host_ok_next   = 1'b0;
        w_state_next     = w_rest_state;
      end else begin
        w_state_next = S_FAULT;
        w_error_next = 1'b1;
      end
    end
  end

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= 3'd0;
      r_retry        <= 2'd0;
      r_cnt          <= 24'd0;
      r_byte         <= 8'h00;
      r_mouse_id     <= 8'h00;
      r_stream_ready <= 1'b0;
      r_error        <= 1'b0;
      r_host_mode    <= 1'b0;
      r_rest_stream  <= 1'b0;
      r_host_done    <= 1'b0;
      r_host_ok      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_ptr          <= w_ptr_next;
      r_retry        <= w_retry_next;
      r_cnt          <= w_cnt_next;
      r_byte         <= w_byte_next;
      r_mouse_id     <= w_mouse_id_next;
      r_stream_ready <= w_stream_ready_next;
      r_error        <= w_error_next;
      r_host_mode    <= w_host_mode_next;
      r_rest_stream  <= w_rest_stream_next;
      r_host_done    <= w_host_done_next;
      r_host_ok      <= w_host_ok_next;
    end
  end

  assign o_host_gnt     = (r_state == S_LOAD) && r_host_mode;
  assign o_host_done    = r_host_done;
  assign o_host_ok      = r_host_ok;
  assign o_send_byte    = (r_state == S_SEND);
  assign o_byte_to_send = r_byte;
  assign o_read_enable  = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_ID);
  assign o_mouse_id     = r_mouse_id;
  assign o_stream_ready = r_stream_ready;
  assign o_busy         = !((r_state == S_IDLE) || (r_state == S_STREAM) || (r_state == S_FAULT));
  assign o_error        = r_error;

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
// Bench for mouse_cmd_sequencer: a scripted mouse answers each sent byte
// according to a per-attempt plan; expected byte streams and final status
// are derived from the plan by a simple attempt-counting model.
module tb_mouse_cmd_sequencer;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_start;
  logic       i_host_req;
  logic [7:0] i_host_byte;
  logic       o_host_gnt;
  logic       o_host_done;
  logic       o_host_ok;
  logic       o_send_byte;
  logic [7:0] o_byte_to_send;
  logic       i_byte_sent;
  logic       o_read_enable;
  logic [7:0] i_byte_read;
  logic [1:0] i_byte_error_code;
  logic       i_byte_ready;
  logic [7:0] o_mouse_id;
  logic       o_stream_ready;
  logic       o_busy;
  logic       o_error;

  always #5 clk = ~clk;

  mouse_cmd_sequencer #(
    .TIMEOUT_CYCLES(24'd100),
    .MAX_RETRY     (2'd3)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (i_reset_n),
    .i_start          (i_start),
    .i_host_req       (i_host_req),
    .i_host_byte      (i_host_byte),
    .o_host_gnt       (o_host_gnt),
    .o_host_done      (o_host_done),
    .o_host_ok        (o_host_ok),
    .o_send_byte      (o_send_byte),
    .o_byte_to_send   (o_byte_to_send),
    .i_byte_sent      (i_byte_sent),
    .o_read_enable    (o_read_enable),
    .i_byte_read      (i_byte_read),
    .i_byte_error_code(i_byte_error_code),
    .i_byte_ready     (i_byte_ready),
    .o_mouse_id       (o_mouse_id),
    .o_stream_ready   (o_stream_ready),
    .o_busy           (o_busy),
    .o_error          (o_error)
  );

  // Mouse reply kinds per attempt: 0 ack, 1 FE, 2 FC, 3 rx error,
  // 4 never transmitted, 5 no reply, 6 reset while awaiting the ack.
  int         n_total = 0;
  int         n_pass  = 0;
  int         cyc     = 0;
  int         gnt_cnt = 0;
  int         done_cnt = 0;
  logic       last_ok = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         plan_q[$];
  logic [7:0] rom [8];
  logic [7:0] id_val;
  logic [7:0] model_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_host_gnt) begin
      gnt_cnt++;
      i_host_req = 1'b0;
    end
    if (o_host_done) begin
      done_cnt++;
      last_ok = o_host_ok;
    end
    if (o_send_byte) got_q.push_back(o_byte_to_send);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {31'd0, o_host_gnt},     32'd0);
    check({tag, "_done"},   {31'd0, o_host_done},    32'd0);
    check({tag, "_ok"},     {31'd0, o_host_ok},      32'd0);
    check({tag, "_send"},   {31'd0, o_send_byte},    32'd0);
    check({tag, "_byte"},   {24'd0, o_byte_to_send}, 32'd0);
    check({tag, "_rden"},   {31'd0, o_read_enable},  32'd0);
    check({tag, "_id"},     {24'd0, o_mouse_id},     32'd0);
    check({tag, "_stream"}, {31'd0, o_stream_ready}, 32'd0);
    check({tag, "_busy"},   {31'd0, o_busy},         32'd0);
    check({tag, "_error"},  {31'd0, o_error},        32'd0);
  endtask

  // Acts as the mouse for one transmitted byte (called in the SEND cycle).
  task automatic respond(input bit host_mode);
    logic [7:0] b;
    int k;
    b = o_byte_to_send;
    k = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
    tick();
    if (k == 4) return;
    i_byte_sent = 1'b1;
    tick();
    i_byte_sent = 1'b0;
    if (k == 5) return;
    if (k == 6) begin
      check("abort_rden", {31'd0, o_read_enable}, 32'd1);
      #2;
      i_reset_n = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (3) tick();
      i_reset_n = 1'b1;
      return;
    end
    tick();
    i_byte_error_code = 2'b00;
    case (k)
      1: i_byte_read = 8'hFE;
      2: i_byte_read = 8'hFC;
      3: begin
        i_byte_read = 8'hFA;
        i_byte_error_code = 2'($urandom_range(1, 3));
      end
      default: i_byte_read = 8'hFA;
    endcase
    i_byte_ready = 1'b1;
    tick();
    i_byte_ready = 1'b0;
    i_byte_error_code = 2'b00;
    if (k == 0 && !host_mode && b == 8'hF2) begin
      i_byte_read = id_val;
      i_byte_ready = 1'b1;
      tick();
      i_byte_ready = 1'b0;
    end
  endtask

  task automatic run_session(input bit host_mode);
    int c0;
    c0 = cyc;
    got_q.delete();
    while (cyc - c0 < 8000) begin
      tick();
      while (o_send_byte && (cyc - c0 < 8000)) respond(host_mode);
      if (!o_busy && got_q.size() > 0) break;
    end
  endtask

  // Script model: each byte is retried until acked or four attempts fail.
  task automatic model_script(output bit ok, output bit id_seen);
    int idx;
    int tries;
    idx = 0;
    ok = 1'b1;
    id_seen = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 8 && ok; p++) begin
      tries = 0;
      forever begin
        exp_q.push_back(rom[p]);
        if (idx >= plan_q.size() || plan_q[idx] == 0) begin
          idx++;
          if (p == 6) id_seen = 1'b1;
          break;
        end
        idx++;
        tries++;
        if (tries > 3) begin
          ok = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic model_host(input logic [7:0] hb, output bit ok);
    int tries;
    tries = 0;
    ok = 1'b0;
    exp_q.delete();
    while (tries <= 3) begin
      exp_q.push_back(hb);
      if (tries >= plan_q.size() || plan_q[tries] == 0) begin
        ok = 1'b1;
        break;
      end
      tries++;
    end
  endtask

  task automatic compare_sends(input string tag);
    check({tag, "_nsend"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_sr_clr", {31'd0, o_stream_ready}, 32'd0);
    check("start_err_clr", {31'd0, o_error}, 32'd0);
    check("start_busy", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic script_test(input string tag);
    bit ok;
    bit id_seen;
    int d0;
    model_script(ok, id_seen);
    if (id_seen) model_id = id_val;
    d0 = done_cnt;
    do_start();
    run_session(1'b0);
    compare_sends(tag);
    check({tag, "_stream"}, {31'd0, o_stream_ready}, {31'd0, ok});
    check({tag, "_error"},  {31'd0, o_error},        {31'd0, !ok});
    check({tag, "_id"},     {24'd0, o_mouse_id},     {24'd0, model_id});
    check({tag, "_busy"},   {31'd0, o_busy},         32'd0);
    check({tag, "_nodone"}, done_cnt - d0,           32'd0);
  endtask

  task automatic host_test(input string tag, input logic [7:0] hb);
    bit ok;
    logic sr0;
    int g0;
    int d0;
    model_host(hb, ok);
    sr0 = o_stream_ready;
    g0 = gnt_cnt;
    d0 = done_cnt;
    i_host_byte = hb;
    i_host_req = 1'b1;
    run_session(1'b1);
    compare_sends(tag);
    check({tag, "_gnt"},    gnt_cnt - g0,            32'd1);
    check({tag, "_done"},   done_cnt - d0,           32'd1);
    check({tag, "_ok"},     {31'd0, last_ok},        {31'd0, ok});
    check({tag, "_stream"}, {31'd0, o_stream_ready}, {31'd0, sr0});
    check({tag, "_id"},     {24'd0, o_mouse_id},     {24'd0, model_id});
    check({tag, "_busy"},   {31'd0, o_busy},         32'd0);
  endtask

  function automatic int rand_kind();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 13) return 0;
    if (r < 15) return 1;
    if (r < 17) return 2;
    if (r < 19) return 3;
    return 4 + int'($urandom_range(0, 1));
  endfunction

  initial begin
    int g0;
    int d0;
    rom = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    model_id = 8'h00;
    id_val = 8'h03;
    i_reset_n = 1'b0;
    i_start = 1'b0;
    i_host_req = 1'b0;
    i_host_byte = 8'h00;
    i_byte_sent = 1'b0;
    i_byte_read = 8'h00;
    i_byte_error_code = 2'b00;
    i_byte_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    i_reset_n = 1'b1;
    tick();

    // Host command from IDLE that exhausts its retries.
    plan_q = '{1, 2, 3, 5};
    host_test("host_idle_fail", 8'hF5);

    // Clean script, mouse ID 03.
    plan_q.delete();
    id_val = 8'h03;
    script_test("script_clean");

    // Two NAKs on the first C8, then ack.
    plan_q = '{0, 1, 1, 0};
    id_val = 8'h03;
    script_test("script_nak_c8");

    // Host command while streaming.
    plan_q.delete();
    host_test("host_e8", 8'hE8);

    // First F3 never leaves the transmitter.
    plan_q = '{4, 4, 4, 4};
    script_test("script_timeout");

    // Host requests are not granted in FAULT.
    g0 = gnt_cnt;
    i_host_byte = 8'h11;
    i_host_req = 1'b1;
    repeat (20) tick();
    i_host_req = 1'b0;
    check("fault_no_gnt", gnt_cnt - g0, 32'd0);
    check("fault_error_held", {31'd0, o_error}, 32'd1);
    check("fault_idle_busy", {31'd0, o_busy}, 32'd0);

    // Randomised scripts, each followed by a random host command when streaming.
    for (int s = 0; s < 4; s++) begin
      plan_q.delete();
      for (int i = 0; i < 40; i++) plan_q.push_back(rand_kind());
      id_val = 8'($urandom_range(0, 255));
      script_test($sformatf("rnd%0d", s));
      if (o_stream_ready) begin
        plan_q.delete();
        for (int i = 0; i < 6; i++) plan_q.push_back(rand_kind());
        host_test($sformatf("rndh%0d", s), 8'($urandom_range(0, 255)));
      end
    end

    // Same-cycle START and HOST_REQ from IDLE: script first, host after STREAM.
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    model_id = 8'h00;
    tick();
    plan_q.delete();
    id_val = 8'h5A;
    model_id = id_val;
    g0 = gnt_cnt;
    i_host_byte = 8'hE6;
    i_host_req = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    run_session(1'b0);
    check("arb_first_byte", (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hDEAD, 32'hF3);
    check("arb_no_gnt_yet", gnt_cnt - g0, 32'd0);
    check("arb_stream", {31'd0, o_stream_ready}, 32'd1);
    plan_q.delete();
    host_test("arb_host", 8'hE6);

    // Reset while awaiting the ack of 64; nothing is sent until the next START.
    plan_q = '{0, 0, 0, 6};
    d0 = done_cnt;
    do_start();
    run_session(1'b0);
    check("abort_nsend", got_q.size(), 32'd4);
    got_q.delete();
    repeat (200) tick();
    check("abort_quiet", got_q.size(), 32'd0);
    check("abort_nodone", done_cnt - d0, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_id", {24'd0, o_mouse_id}, 32'd0);
    model_id = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mouse_cmd_sequencer.md
MOUSE_CMD_SEQUENCER -- requirements
Module: mouse_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5000000, SHALL set the per-phase response timeout (100 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 2'd3, SHALL set the number of resends allowed per command byte.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 START  in  1  SHALL request, as a one-cycle pulse, execution of the configuration script.
REQ-006 HOST_REQ  in  1 / HOST_BYTE  in  8  SHALL be a host command request, held until HOST_GNT.
REQ-007 HOST_GNT  out  1  SHALL pulse one cycle when HOST_BYTE is latched for sending.
REQ-008 HOST_DONE  out  1 / HOST_OK  out  1  SHALL pulse together at host-command completion; HOST_OK=1 only if ACK FA received.
REQ-009 SEND_BYTE  out  1 / BYTE_TO_SEND  out  8 / BYTE_SENT  in  1  SHALL drive the PS/2 transmitter.
REQ-010 READ_ENABLE  out  1 / BYTE_READ  in  8 / BYTE_ERROR_CODE  in  2 / BYTE_READY  in  1  SHALL drive the PS/2 receiver.
REQ-011 MOUSE_ID  out  8  SHALL hold the device ID captured after command F2.
REQ-012 STREAM_READY  out  1 / BUSY  out  1 / ERROR  out  1  SHALL report stream-enabled, sequence-active, and fault status.

Function
REQ-013 Script SHALL be the fixed 8-entry ROM F3,C8,F3,64,F3,50,F2,F4 indexed by a 3-bit pointer.
REQ-014 States SHALL be IDLE, LOAD, SEND, WAIT_SENT, WAIT_ACK, WAIT_ID, NEXT, STREAM, FAULT.
REQ-015 IDLE/STREAM/FAULT + START SHALL go to LOAD with pointer=0, retry=0, STREAM_READY and ERROR cleared next cycle.
REQ-016 LOAD SHALL latch ROM[pointer] (script) or HOST_BYTE (host) into BYTE_TO_SEND, then SEND.
REQ-017 SEND SHALL assert SEND_BYTE for exactly one cycle, then WAIT_SENT; BYTE_TO_SEND SHALL stay stable until next LOAD.
REQ-018 WAIT_SENT SHALL move to WAIT_ACK on BYTE_SENT.
REQ-019 READ_ENABLE SHALL be 1 in WAIT_ACK and WAIT_ID, 0 elsewhere.
REQ-020 WAIT_ACK with BYTE_READY, BYTE_READ=FA, BYTE_ERROR_CODE=00 SHALL succeed: to WAIT_ID if the byte was script F2, else NEXT.
REQ-021 WAIT_ID with BYTE_READY and BYTE_ERROR_CODE=00 SHALL capture BYTE_READ into MOUSE_ID, then NEXT.
REQ-022 Failure = timeout, BYTE_READY with BYTE_ERROR_CODE≠00, or ack byte ≠ FA (incl. FE, FC).
REQ-023 On failure with retry<MAX_RETRY: retry+1, return to SEND with same BYTE_TO_SEND.
REQ-024 On failure with retry=MAX_RETRY: script -> FAULT with ERROR=1; host -> HOST_DONE=1, HOST_OK=0, return to prior resting state.
REQ-025 Timeout counter (24 bit) SHALL clear on entry to WAIT_SENT, WAIT_ACK, WAIT_ID and fail at TIMEOUT_CYCLES-1.
REQ-026 NEXT for script: retry=0; pointer 7 -> STREAM with STREAM_READY=1; else pointer+1 -> LOAD. Pointer SHALL not wrap.
REQ-027 NEXT for host: HOST_DONE=1, HOST_OK=1, return to resting state (IDLE or STREAM) held on acceptance.
REQ-028 Host arbitration: HOST_REQ SHALL be granted only in IDLE or STREAM; START wins on same-cycle START and HOST_REQ.
REQ-029 Host commands SHALL not alter STREAM_READY or MOUSE_ID.
REQ-030 START while in LOAD..NEXT SHALL be ignored.
REQ-031 BUSY SHALL be 1 in every state except IDLE, STREAM, FAULT.
REQ-032 FAULT SHALL hold ERROR=1 until START or reset; HOST_REQ SHALL not be granted in FAULT.

Reset
REQ-033 RESET=0 SHALL immediately force IDLE, pointer=0, retry=0, counter=0, all 1-bit outputs 0, BYTE_TO_SEND=00, MOUSE_ID=00.
REQ-034 Reset mid-transaction SHALL abort without completion pulses; first SEND_BYTE after release only follows START.

Verification
REQ-035 START, model acks FA each byte, returns 03 after F2 -> 8 SEND_BYTE pulses in ROM order, MOUSE_ID=03, STREAM_READY=1, BUSY=0.
REQ-036 Reply FE to first C8 twice then FA -> C8 sent 3 times, script completes, ERROR=0.
REQ-037 No BYTE_SENT after first F3, TIMEOUT_CYCLES=100 -> 4 sends of F3, FAULT, ERROR=1, BUSY=0.
REQ-038 In STREAM, HOST_REQ with HOST_BYTE=E8, ack FA -> HOST_GNT once, HOST_DONE=HOST_OK=1, STREAM_READY stays 1.
REQ-039 Same-cycle START and HOST_REQ in IDLE -> first BYTE_TO_SEND=F3, no HOST_GNT until STREAM.
REQ-040 RESET low during WAIT_ACK of byte 64 -> all outputs 00/0 asynchronously, no SEND_BYTE until next START.
